// File: rtl/memory_access_unit.sv
// Load/store alignment stage: extracts and extends load data, merges store data into
// the addressed word with byte enables. Optional MAU_MISALIGN_CHECK_EN flags unaligned accesses.
module memory_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic        is_store_i,
    input  logic [2:0]  function3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] data_in,
    input  logic [31:0] old_word,
    output logic [31:0] data_out,
    output logic [3:0]  byte_en,
    output logic        valid_o,
    output logic        illegal_o,
    output logic        misaligned_o
);

    localparam int STAGES = 1;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
        logic        ill;
        logic        mis;
    } rsp_t;

    logic [1:0]  size;
    logic [1:0]  off;
    logic        illegal, mis_raw, misaligned, reject;
    logic [31:0] ld_shift, ld_val, st_data, merged;
    logic [3:0]  st_be, be_d;
    rsp_t        rsp_d, rsp_q;
    logic [STAGES:1] vld_pipe;

    assign size = function3[1:0];

    always_comb begin
        illegal = is_store_i ? (function3 > 3'b010)
                             : (size == 2'b11 || function3 == 3'b110);
        mis_raw = (size == 2'b01 && byte_off[0]) || (size == 2'b10 && byte_off != 2'b00);
`ifdef MAU_MISALIGN_CHECK_EN
        misaligned = mis_raw;
`else
        misaligned = 1'b0;
`endif
        reject = illegal | misaligned;
    end

    // Effective lane offset; halfword/word accesses are force-aligned.
    always_comb begin
        case (size)
            2'b00:   off = byte_off;
            2'b01:   off = {byte_off[1], 1'b0};
            default: off = 2'b00;
        endcase
    end

    always_comb begin
        ld_shift = data_in >> {off, 3'b000};
        case (size)
            2'b00:   ld_val = {{24{~function3[2] & ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_val = {{16{~function3[2] & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_val = ld_shift;
        endcase
    end

    // Store data replicated across lanes; byte enables pick which copies land.
    always_comb begin
        case (size)
            2'b00: begin
                st_data = {4{data_in[7:0]}};
                st_be   = 4'b0001 << off;
            end
            2'b01: begin
                st_data = {2{data_in[15:0]}};
                st_be   = 4'b0011 << off;
            end
            default: begin
                st_data = data_in;
                st_be   = 4'b1111;
            end
        endcase
        be_d = (is_store_i && !reject) ? st_be : 4'b0000;
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[8*i +: 8] = be_d[i] ? st_data[8*i +: 8] : old_word[8*i +: 8];
    end

    always_comb begin
        rsp_d.data = is_store_i ? merged : (reject ? 32'h0 : ld_val);
        rsp_d.be   = be_d;
        rsp_d.ill  = illegal;
        rsp_d.mis  = misaligned;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            rsp_q    <= '0;
        end else begin
            vld_pipe[1] <= valid_i;
            if (valid_i) begin
                rsp_q <= rsp_d;
            end else begin
                // data holds its last value between requests
                rsp_q.be  <= 4'b0000;
                rsp_q.ill <= 1'b0;
                rsp_q.mis <= 1'b0;
            end
        end
    end

    assign valid_o      = vld_pipe[STAGES];
    assign data_out     = rsp_q.data;
    assign byte_en      = rsp_q.be;
    assign illegal_o    = rsp_q.ill;
    assign misaligned_o = rsp_q.mis;

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit: driver pushes model results, a monitor
// pops and compares each valid_o beat and checks idle/reset output values.
module tb_memory_access_unit;

    logic        clk = 1'b0;
    logic        rst_n, valid_i, is_store_i;
    logic [2:0]  function3;
    logic [1:0]  byte_off;
    logic [31:0] data_in, old_word, data_out;
    logic [3:0]  byte_en;
    logic        valid_o, illegal_o, misaligned_o;

    memory_access_unit dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .is_store_i(is_store_i),
        .function3(function3), .byte_off(byte_off), .data_in(data_in),
        .old_word(old_word), .data_out(data_out), .byte_en(byte_en),
        .valid_o(valid_o), .illegal_o(illegal_o), .misaligned_o(misaligned_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  be;
        logic        ill;
        logic        mis;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] last_d = 32'h0;

    // Reference: access width in bytes from funct3, lanes addressed by offset.
    function automatic exp_t model(input bit st, input bit [2:0] f3, input bit [1:0] off,
                                   input bit [31:0] din, input bit [31:0] old);
        exp_t        e;
        int          nb, o, a;
        logic [63:0] v, mask;
        nb = 1 << int'(f3[1:0]);
        o  = int'(off);
        a  = o - (o % nb);
        e.ill = st ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e.mis = 1'b0;
`ifdef MAU_MISALIGN_CHECK_EN
        e.mis = (nb == 2 || nb == 4) && (o % nb != 0);
`endif
        e.be  = 4'b0000;
        e.due = 0;
        if (e.ill || e.mis) begin
            e.d = st ? old : 32'h0;
        end else if (!st) begin
            v = {32'h0, din} >> (8 * a);
            if (nb < 4) begin
                mask = (64'd1 << (8 * nb)) - 64'd1;
                v = v & mask;
                if (!f3[2] && v[8*nb-1]) v = v | ~mask;
            end
            e.d = v[31:0];
        end else begin
            e.d = old;
            for (int k = 0; k < nb; k++) begin
                e.d[8*(a+k) +: 8] = din[8*k +: 8];
                e.be[a+k] = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    task automatic issue(input bit v, input bit st, input bit [2:0] f3, input bit [1:0] off,
                         input bit [31:0] din, input bit [31:0] old, input bit rst);
        exp_t e;
        @(negedge clk);
        rst_n = rst; valid_i = v; is_store_i = st; function3 = f3;
        byte_off = off; data_in = din; old_word = old;
        if (v && rst) begin
            e = model(st, f3, off, din, old);
            e.due = cyc + 1;
            q.push_back(e);
        end
    endtask

    // Monitor: sample 2ns after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        bit   r, chk_mis;
        cyc++;
        r = rst_n;
        #2;
        if (!r) begin
            check("reset_outputs", {data_out, 3'b0, byte_en, valid_o, illegal_o, misaligned_o}, 40'h0);
            last_d = 32'h0;
        end else if (valid_o) begin
            if (q.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk_mis = 1'b1;
`ifdef MAU_MISALIGN_CHECK_EN
                chk_mis = !e.ill;
`endif
                check("latency", cyc, e.due);
                check("data_out", data_out, e.d);
                check("byte_en", {28'h0, byte_en}, {28'h0, e.be});
                check("illegal_o", {31'h0, illegal_o}, {31'h0, e.ill});
                if (chk_mis) check("misaligned_o", {31'h0, misaligned_o}, {31'h0, e.mis});
                last_d = e.d;
            end
        end else begin
            check("idle_flags", {26'h0, byte_en, illegal_o, misaligned_o}, 32'h0);
            check("idle_hold", data_out, last_d);
            if (q.size() != 0 && q[0].due <= cyc) begin
                check("missing_valid", 32'd0, 32'd1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; valid_i = 1'b1; is_store_i = 1'b0; function3 = 3'b010;
        byte_off = 2'b00; data_in = 32'hDEADBEEF; old_word = 32'h0;
        // Reset held with valid_i high: requests dropped, outputs zero
        repeat (3) issue(1, 0, 3'b010, 0, 32'hDEADBEEF, 32'h0, 0);
        issue(1, 0, 3'b001, 0, 32'h1234ABCD, 32'h0, 1);
        issue(1, 0, 3'b000, 0, 32'h7FFFFF80, 32'h0, 1);
        issue(1, 0, 3'b100, 3, 32'hFF00AA55, 32'h0, 1);
        issue(1, 0, 3'b010, 0, 32'hDEADBEEF, 32'h0, 1);
        issue(1, 1, 3'b001, 2, 32'h00001234, 32'hCAFEBABE, 1);
        issue(1, 1, 3'b000, 1, 32'h000000AB, 32'hCAFEBABE, 1);
        issue(1, 0, 3'b011, 0, 32'h55555555, 32'h0, 1);
        issue(1, 1, 3'b100, 0, 32'h11223344, 32'hCAFEBABE, 1);
        issue(0, 0, 3'b000, 0, 32'h0, 32'h0, 1);
        issue(1, 0, 3'b010, 1, 32'h12345678, 32'h0, 1);
        issue(1, 1, 3'b010, 0, 32'hA5A5A5A5, 32'h01020304, 1);
        issue(1, 0, 3'b010, 0, 32'h0BADF00D, 32'h0, 1);
        issue(1, 1, 3'b001, 3, 32'h0000BEEF, 32'h87654321, 1);
        issue(1, 0, 3'b101, 1, 32'h8001FFFE, 32'h0, 1);
        // Mid-stream reset pulse with a simultaneous request
        issue(1, 0, 3'b010, 0, 32'hFFFFFFFF, 32'h0, 0);
        issue(1, 0, 3'b000, 2, 32'h00800000, 32'h0, 1);
        for (int i = 0; i < 500; i++) begin
            issue($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, 3'($urandom_range(7, 0)),
                  2'($urandom_range(3, 0)), $urandom, $urandom, $urandom_range(39, 0) != 0);
        end
        repeat (3) issue(0, 0, 3'b000, 0, 32'h0, 32'h0, 1);
        @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
